// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the Ethernet receive FCS-strip path.
// The frame-length helper saturates so very long frames remain flagged oversize.
package eth_rx_pkg;

    localparam int ETH_FCS_LEN       = 4;
    localparam int DEF_MIN_FRAME_LEN = 64;
    localparam int DEF_MAX_FRAME_LEN = 1518;

    typedef enum logic [1:0] {
        DISCARD = 2'd0,
        IDLE    = 2'd1,
        FILL    = 2'd2,
        STREAM  = 2'd3
    } rx_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_rx_stats_counters.sv
// Wrapping 32-bit receive statistics, fed by per-frame event strobes.
// A clear that coincides with an update wins and the update is dropped.
module eth_rx_stats_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_stats,
    input  logic        frame_ok,
    input  logic        frame_bad,
    input  logic        runt,
    input  logic        oversize,
    input  logic        fcs_err,
    input  logic [15:0] bytes_delta,
    output logic [31:0] stat_frames_ok,
    output logic [31:0] stat_frames_bad,
    output logic [31:0] stat_bytes_ok,
    output logic [31:0] stat_runt,
    output logic [31:0] stat_oversize,
    output logic [31:0] stat_fcs_err
);

    logic [31:0] ok_r;
    logic [31:0] bad_r;
    logic [31:0] bytes_r;
    logic [31:0] runt_r;
    logic [31:0] over_r;
    logic [31:0] fcs_r;

    // counter registers with clear priority over increments
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ok_r    <= 32'd0;
            bad_r   <= 32'd0;
            bytes_r <= 32'd0;
            runt_r  <= 32'd0;
            over_r  <= 32'd0;
            fcs_r   <= 32'd0;
        end else if (clr_stats) begin
            ok_r    <= 32'd0;
            bad_r   <= 32'd0;
            bytes_r <= 32'd0;
            runt_r  <= 32'd0;
            over_r  <= 32'd0;
            fcs_r   <= 32'd0;
        end else begin
            if (frame_ok) begin
                ok_r    <= ok_r + 32'd1;
                bytes_r <= bytes_r + {16'd0, bytes_delta};
            end
            if (frame_bad) begin
                bad_r <= bad_r + 32'd1;
            end
            if (runt) begin
                runt_r <= runt_r + 32'd1;
            end
            if (oversize) begin
                over_r <= over_r + 32'd1;
            end
            if (fcs_err) begin
                fcs_r <= fcs_r + 32'd1;
            end
        end
    end

    assign stat_frames_ok  = ok_r;
    assign stat_frames_bad = bad_r;
    assign stat_bytes_ok   = bytes_r;
    assign stat_runt       = runt_r;
    assign stat_oversize   = over_r;
    assign stat_fcs_err    = fcs_r;

endmodule

// File: rtl/axis_eth_rx_fcs_strip.sv
// Strips the trailing FCS from a non-stallable byte stream using a 4-byte delay line,
// flags runt/oversize/FCS-bad frames on the last beat and drives the receive statistics.
module axis_eth_rx_fcs_strip
    import eth_rx_pkg::*;
#(
    parameter int MIN_FRAME_LEN = DEF_MIN_FRAME_LEN,
    parameter int MAX_FRAME_LEN = DEF_MAX_FRAME_LEN,
    parameter bit DROP_BAD_FCS  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    input  logic        s_fcs_bad,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    input  logic        clr_stats,
    output logic [31:0] stat_frames_ok,
    output logic [31:0] stat_frames_bad,
    output logic [31:0] stat_bytes_ok,
    output logic [31:0] stat_runt,
    output logic [31:0] stat_oversize,
    output logic [31:0] stat_fcs_err
);

    localparam logic [15:0] MIN_LEN_C  = 16'(MIN_FRAME_LEN);
    localparam logic [15:0] MAX_LEN_C  = 16'(MAX_FRAME_LEN);
    localparam logic [15:0] FCS_LEN_C  = 16'(ETH_FCS_LEN);
    localparam logic [15:0] EMIT_LEN_C = 16'(ETH_FCS_LEN + 1);
    localparam logic [2:0]  FULL_C     = 3'(ETH_FCS_LEN);

    rx_state_e                     state_r, state_nxt_s;
    logic [2:0]                    cnt_r, cnt_nxt_s;
    logic [15:0]                   len_r, len_nxt_s, frame_len_s;
    logic [ETH_FCS_LEN-1:0][7:0]   buf_r, buf_nxt_s;
    logic [7:0]                    tdata_r, tdata_nxt_s;
    logic                          tvalid_r, tvalid_nxt_s;
    logic                          tlast_r, tlast_nxt_s;
    logic                          tuser_r, tuser_nxt_s;
    logic                          runt_s, over_s;
    logic                          ok_stb_s, bad_stb_s, runt_stb_s, over_stb_s, fcs_stb_s;
    logic [15:0]                   bytes_delta_s;

    // next-state, delay-line and output-beat decode; everything holds without tvalid
    always_comb begin
        frame_len_s   = sat_inc16(len_r);
        runt_s        = (frame_len_s < MIN_LEN_C);
        over_s        = (frame_len_s > MAX_LEN_C);
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        len_nxt_s     = len_r;
        buf_nxt_s     = buf_r;
        tdata_nxt_s   = tdata_r;
        tvalid_nxt_s  = 1'b0;
        tlast_nxt_s   = 1'b0;
        tuser_nxt_s   = 1'b0;
        ok_stb_s      = 1'b0;
        bad_stb_s     = 1'b0;
        runt_stb_s    = 1'b0;
        over_stb_s    = 1'b0;
        fcs_stb_s     = 1'b0;
        bytes_delta_s = 16'd0;
        if (s_axis_tvalid) begin
            case (state_r)
                DISCARD: begin
                    if (s_axis_tlast) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DISCARD;
                    end
                end
                IDLE, FILL, STREAM: begin
                    if (s_axis_tlast) begin
                        // with at least one payload byte, the oldest buffered byte is the last payload byte
                        if (frame_len_s >= EMIT_LEN_C) begin
                            tvalid_nxt_s  = 1'b1;
                            tdata_nxt_s   = buf_r[0];
                            tlast_nxt_s   = 1'b1;
                            tuser_nxt_s   = s_axis_tuser | runt_s | over_s | (DROP_BAD_FCS & s_fcs_bad);
                            ok_stb_s      = ~tuser_nxt_s;
                            bad_stb_s     = tuser_nxt_s;
                            bytes_delta_s = frame_len_s - FCS_LEN_C;
                        end else begin
                            bad_stb_s = 1'b1;
                        end
                        runt_stb_s  = runt_s;
                        over_stb_s  = over_s;
                        fcs_stb_s   = s_fcs_bad;
                        cnt_nxt_s   = 3'd0;
                        len_nxt_s   = 16'd0;
                        state_nxt_s = IDLE;
                    end else begin
                        len_nxt_s = frame_len_s;
                        if (cnt_r == FULL_C) begin
                            tvalid_nxt_s = 1'b1;
                            tdata_nxt_s  = buf_r[0];
                            for (int i = 0; i < ETH_FCS_LEN - 1; i++) begin
                                buf_nxt_s[i] = buf_r[i+1];
                            end
                            buf_nxt_s[ETH_FCS_LEN-1] = s_axis_tdata;
                            state_nxt_s = STREAM;
                        end else begin
                            buf_nxt_s[cnt_r[1:0]] = s_axis_tdata;
                            cnt_nxt_s = cnt_r + 3'd1;
                            if (cnt_r == FULL_C - 3'd1) begin
                                state_nxt_s = STREAM;
                            end else begin
                                state_nxt_s = FILL;
                            end
                        end
                    end
                end
                default: begin
                    state_nxt_s = DISCARD;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // state, delay line and registered output beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= DISCARD;
            cnt_r    <= 3'd0;
            len_r    <= 16'd0;
            buf_r    <= '0;
            tdata_r  <= 8'd0;
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
            tuser_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            len_r    <= len_nxt_s;
            buf_r    <= buf_nxt_s;
            tdata_r  <= tdata_nxt_s;
            tvalid_r <= tvalid_nxt_s;
            tlast_r  <= tlast_nxt_s;
            tuser_r  <= tuser_nxt_s;
        end
    end

    assign m_axis_tdata  = tdata_r;
    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tlast  = tlast_r;
    assign m_axis_tuser  = tuser_r;

    eth_rx_stats_counters u_stats (
        .clk             (clk),
        .rst_n           (rst_n),
        .clr_stats       (clr_stats),
        .frame_ok        (ok_stb_s),
        .frame_bad       (bad_stb_s),
        .runt            (runt_stb_s),
        .oversize        (over_stb_s),
        .fcs_err         (fcs_stb_s),
        .bytes_delta     (bytes_delta_s),
        .stat_frames_ok  (stat_frames_ok),
        .stat_frames_bad (stat_frames_bad),
        .stat_bytes_ok   (stat_bytes_ok),
        .stat_runt       (stat_runt),
        .stat_oversize   (stat_oversize),
        .stat_fcs_err    (stat_fcs_err)
    );

endmodule

// File: tb/tb_axis_eth_rx_fcs_strip.sv
// Self-checking bench: table of frames with hand-computed results, hand sequences for
// reset mid-frame and stats clear, then random frames checked against a frame-level model.
module tb_axis_eth_rx_fcs_strip;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tuser;
    logic        s_fcs_bad;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        clr_stats;
    logic [31:0] stat_frames_ok;
    logic [31:0] stat_frames_bad;
    logic [31:0] stat_bytes_ok;
    logic [31:0] stat_runt;
    logic [31:0] stat_oversize;
    logic [31:0] stat_fcs_err;

    always #5 clk = ~clk;

    axis_eth_rx_fcs_strip dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tuser    (s_axis_tuser),
        .s_fcs_bad       (s_fcs_bad),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tuser    (m_axis_tuser),
        .clr_stats       (clr_stats),
        .stat_frames_ok  (stat_frames_ok),
        .stat_frames_bad (stat_frames_bad),
        .stat_bytes_ok   (stat_bytes_ok),
        .stat_runt       (stat_runt),
        .stat_oversize   (stat_oversize),
        .stat_fcs_err    (stat_fcs_err)
    );

    typedef struct {
        int ok;
        int bad;
        int runt;
        int over;
        int fcs;
        int bytes;
    } stat_d_t;

    typedef struct {
        int      len;
        int      pace;
        logic    tu;
        logic    fcs;
        int      n_out;
        logic    user;
        stat_d_t d;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    localparam int NV = 13;

    int      n_chk = 0;
    int      n_pass = 0;
    int      cyc = 0;
    int      out_cnt = 0;
    beat_t   sb[$];
    beat_t   mon_e;
    stat_d_t exp_st;
    vec_t    vecs[NV];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // output monitor: every beat must match the next expected beat, including its cycle
    always @(negedge clk) begin
        if (rst_n === 1'b1 && m_axis_tvalid === 1'b1) begin
            out_cnt++;
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_beat: got data %0h last %0b user %0b expected no beat",
                         m_axis_tdata, m_axis_tlast, m_axis_tuser);
            end else begin
                mon_e = sb.pop_front();
                chk("beat", {cyc[21:0], m_axis_tdata, m_axis_tlast, m_axis_tuser},
                    {mon_e.cyc[21:0], mon_e.data, mon_e.last, mon_e.user});
            end
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_stats(input string tag);
        chk({tag, "_frames_ok"},  stat_frames_ok,  exp_st.ok);
        chk({tag, "_frames_bad"}, stat_frames_bad, exp_st.bad);
        chk({tag, "_bytes_ok"},   stat_bytes_ok,   exp_st.bytes);
        chk({tag, "_runt"},       stat_runt,       exp_st.runt);
        chk({tag, "_oversize"},   stat_oversize,   exp_st.over);
        chk({tag, "_fcs_err"},    stat_fcs_err,    exp_st.fcs);
    endtask

    task automatic drive_beat(input logic [7:0] d, input logic last, input logic tu,
                              input logic fcs, input logic clr);
        @(negedge clk);
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        s_axis_tuser  = tu;
        s_fcs_bad     = fcs;
        clr_stats     = clr;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            s_axis_tdata  = 8'($urandom);
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            s_axis_tuser  = 1'b0;
            s_fcs_bad     = 1'b0;
            clr_stats     = 1'b0;
        end
    endtask

    // frame-level reference: outcome follows only from length and the two error inputs
    function automatic void model(input int n, input logic tu, input logic fcs,
                                  output logic user, output stat_d_t d);
        d    = '{default: 0};
        user = tu | (n < 64) | (n > 1518) | fcs;
        if (n < 64) d.runt = 1;
        if (n > 1518) d.over = 1;
        if (fcs) d.fcs = 1;
        if (n <= 4) begin
            d.bad = 1;
        end else if (user) begin
            d.bad = 1;
        end else begin
            d.ok    = 1;
            d.bytes = n - 4;
        end
    endfunction

    // pace < 0 means random 0..2 idle cycles between beats; clr_at = beat index carrying clr_stats
    task automatic drive_frame(input int n, input int pace, input logic tu, input logic fcs,
                               input logic exp_user, input stat_d_t d, input int clr_at);
        logic [7:0] fb[$];
        fb = {};
        for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
        for (int i = 0; i < n; i++) begin
            logic last_b;
            last_b = (i == n - 1);
            drive_beat(fb[i], last_b, last_b & tu, last_b & fcs, (i == clr_at));
            if (i == clr_at) begin
                check_stats("pre_clr");
                exp_st = '{default: 0};
            end
            if (n >= 5 && i >= 4) sb.push_back('{cyc + 1, fb[i-4], last_b, last_b & exp_user});
            if (!last_b) begin
                if (pace < 0) idle($urandom_range(2, 0));
                else idle(pace);
            end
        end
        if (clr_at != n - 1) begin
            exp_st.ok    += d.ok;
            exp_st.bad   += d.bad;
            exp_st.runt  += d.runt;
            exp_st.over  += d.over;
            exp_st.fcs   += d.fcs;
            exp_st.bytes += d.bytes;
        end
    endtask

    initial begin
        stat_d_t zd;
        stat_d_t rd;
        logic    ru;
        logic [7:0] rb[$];
        zd = '{default: 0};
        exp_st = '{default: 0};

        //        len  pace tu    fcs   n_out user   ok bad runt over fcs bytes
        vecs[0]  = '{64,   0, 1'b0, 1'b0, 60,   1'b0, '{1, 0, 0, 0, 0, 60}};
        vecs[1]  = '{64,   1, 1'b0, 1'b0, 60,   1'b0, '{1, 0, 0, 0, 0, 60}};
        vecs[2]  = '{3,    0, 1'b0, 1'b0, 0,    1'b0, '{0, 1, 1, 0, 0, 0}};
        vecs[3]  = '{30,   0, 1'b0, 1'b0, 26,   1'b1, '{0, 1, 1, 0, 0, 0}};
        vecs[4]  = '{1519, 0, 1'b0, 1'b1, 1515, 1'b1, '{0, 1, 0, 1, 1, 0}};
        vecs[5]  = '{1,    0, 1'b0, 1'b0, 0,    1'b0, '{0, 1, 1, 0, 0, 0}};
        vecs[6]  = '{4,    1, 1'b0, 1'b0, 0,    1'b0, '{0, 1, 1, 0, 0, 0}};
        vecs[7]  = '{5,    0, 1'b0, 1'b0, 1,    1'b1, '{0, 1, 1, 0, 0, 0}};
        vecs[8]  = '{1518, 0, 1'b0, 1'b0, 1514, 1'b0, '{1, 0, 0, 0, 0, 1514}};
        vecs[9]  = '{64,   0, 1'b1, 1'b0, 60,   1'b1, '{0, 1, 0, 0, 0, 0}};
        vecs[10] = '{65,   0, 1'b0, 1'b1, 61,   1'b1, '{0, 1, 0, 0, 1, 0}};
        vecs[11] = '{63,   2, 1'b0, 1'b0, 59,   1'b1, '{0, 1, 1, 0, 0, 0}};
        vecs[12] = '{4,    0, 1'b0, 1'b1, 0,    1'b0, '{0, 1, 1, 0, 1, 0}};

        rst_n = 1'b0;
        idle(3);
        chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("rst_tlast",  {31'd0, m_axis_tlast},  32'd0);
        chk("rst_tuser",  {31'd0, m_axis_tuser},  32'd0);
        chk("rst_tdata",  {24'd0, m_axis_tdata},  32'd0);
        check_stats("rst");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // first frame after reset is consumed silently until its tlast
        out_cnt = 0;
        for (int i = 0; i < 10; i++) drive_beat(8'($urandom), (i == 9), 1'b0, 1'b0, 1'b0);
        idle(3);
        chk("discard_out_bytes", out_cnt, 0);
        check_stats("discard");

        for (int v = 0; v < NV; v++) begin
            out_cnt = 0;
            drive_frame(vecs[v].len, vecs[v].pace, vecs[v].tu, vecs[v].fcs,
                        vecs[v].user, vecs[v].d, -1);
            idle(3);
            chk($sformatf("vec%0d_out_bytes", v), out_cnt, vecs[v].n_out);
            check_stats($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_pending", v), sb.size(), 0);
        end

        // reset asserted at byte 20 of a 100-byte frame, released at byte 30
        out_cnt = 0;
        rb = {};
        for (int i = 0; i < 100; i++) rb.push_back(8'($urandom));
        for (int i = 0; i < 20; i++) begin
            drive_beat(rb[i], 1'b0, 1'b0, 1'b0, 1'b0);
            if (i >= 4) sb.push_back('{cyc + 1, rb[i-4], 1'b0, 1'b0});
        end
        idle(1);
        @(negedge clk);
        rst_n = 1'b0;
        exp_st = '{default: 0};
        for (int i = 20; i < 30; i++) drive_beat(rb[i], 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        rst_n = 1'b1;
        for (int i = 30; i < 100; i++) drive_beat(rb[i], (i == 99), 1'b0, 1'b0, 1'b0);
        idle(3);
        chk("rstmid_out_bytes", out_cnt, 16);
        check_stats("rstmid");
        out_cnt = 0;
        drive_frame(64, 0, 1'b0, 1'b0, 1'b0, '{1, 0, 0, 0, 0, 60}, -1);
        idle(3);
        chk("after_rst_out_bytes", out_cnt, 60);
        check_stats("after_rst");

        // back-to-back frames, clr_stats on the first beat of the second frame
        out_cnt = 0;
        drive_frame(64, 0, 1'b0, 1'b0, 1'b0, '{1, 0, 0, 0, 0, 60}, -1);
        drive_frame(64, 0, 1'b0, 1'b0, 1'b0, '{1, 0, 0, 0, 0, 60}, 0);
        @(negedge clk);
        check_stats("b2b_cleared");
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        idle(3);
        chk("b2b_out_bytes", out_cnt, 120);
        check_stats("b2b");

        // clear coinciding with a frame's tlast: that frame's update is lost
        drive_frame(70, 0, 1'b0, 1'b1, 1'b1, '{0, 1, 0, 0, 1, 0}, 69);
        idle(3);
        check_stats("clr_on_last");

        // random frames, mostly back-to-back, with random MII-style gaps
        for (int f = 0; f < 30; f++) begin
            int   n;
            logic tu;
            logic fc;
            if (f % 10 == 9) n = $urandom_range(1530, 1505);
            else n = $urandom_range(100, 1);
            tu = ($urandom_range(7, 0) == 0);
            fc = ($urandom_range(5, 0) == 0);
            model(n, tu, fc, ru, rd);
            drive_frame(n, (f % 2 == 0) ? 0 : -1, tu, fc, ru, rd, -1);
            idle($urandom_range(2, 0));
        end
        idle(3);
        check_stats("rand");
        chk("rand_pending", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
